// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX stage: ALU op codes, bypass selects, control payload.
package id_ex_stage_pkg;

    localparam int unsigned DW_DEF  = 32;
    localparam int unsigned RAW_DEF = 5;
    localparam int unsigned OPW     = 4;
    localparam int unsigned FSW     = 2;

    localparam logic [OPW-1:0] ALU_PASSA = 4'h0;
    localparam logic [OPW-1:0] ALU_ADD   = 4'h1;
    localparam logic [OPW-1:0] ALU_SUB   = 4'h2;
    localparam logic [OPW-1:0] ALU_AND   = 4'h3;
    localparam logic [OPW-1:0] ALU_OR    = 4'h4;
    localparam logic [OPW-1:0] ALU_XOR   = 4'h5;
    localparam logic [OPW-1:0] ALU_NOR   = 4'h6;
    localparam logic [OPW-1:0] ALU_SLT   = 4'h7;

    localparam logic [FSW-1:0] FWD_RF    = 2'd0;
    localparam logic [FSW-1:0] FWD_EXMEM = 2'd1;
    localparam logic [FSW-1:0] FWD_MEMWB = 2'd2;

    // Control bits carried alongside the operands into EX.
    typedef struct packed {
        logic [OPW-1:0] alu_op;
        logic           alu_src;
        logic           reg_write;
        logic           mem_read;
        logic           mem_write;
        logic           mem_to_reg;
    } ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// Per-operand bypass mux: EX/MEM beats MEM/WB beats register-file data; $0 never forwards.
module id_ex_stage_fwd_sel
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DW  = DW_DEF,
    parameter int unsigned RAW = RAW_DEF
) (
    input  logic [RAW-1:0] addr,
    input  logic [DW-1:0]  rf_data,
    input  logic           ex_mem_reg_write,
    input  logic [RAW-1:0] ex_mem_rd,
    input  logic [DW-1:0]  ex_mem_result,
    input  logic           mem_wb_reg_write,
    input  logic [RAW-1:0] mem_wb_rd,
    input  logic [DW-1:0]  mem_wb_result,
    output logic [DW-1:0]  data_c
);

    logic [FSW-1:0] sel;

    always_comb begin
        sel = FWD_RF;
        if (mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == addr)) begin
            sel = FWD_MEMWB;
        end
        if (ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == addr)) begin
            sel = FWD_EXMEM;
        end
    end

    always_comb begin
        data_c = rf_data;
        case (sel)
            FWD_EXMEM: data_c = ex_mem_result;
            FWD_MEMWB: data_c = mem_wb_result;
            default:   data_c = rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall toward decode.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DW  = DW_DEF,
    parameter int unsigned RAW = RAW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DW-1:0]  rs_data,
    input  logic [DW-1:0]  rt_data,
    input  logic [DW-1:0]  imm,
    input  logic [RAW-1:0] rs_addr,
    input  logic [RAW-1:0] rt_addr,
    input  logic [RAW-1:0] rd_addr_in,
    input  logic [OPW-1:0] alu_op_in,
    input  logic           alu_src_in,
    input  logic           reg_write_in,
    input  logic           mem_read_in,
    input  logic           mem_write_in,
    input  logic           mem_to_reg_in,
    input  logic           flush,
    input  logic           ex_mem_reg_write,
    input  logic [RAW-1:0] ex_mem_rd,
    input  logic [DW-1:0]  ex_mem_result,
    input  logic           mem_wb_reg_write,
    input  logic [RAW-1:0] mem_wb_rd,
    input  logic [DW-1:0]  mem_wb_result,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  input_a,
    output logic [DW-1:0]  input_b,
    output logic [OPW-1:0] alu_op,
    output logic [DW-1:0]  store_data,
    output logic [RAW-1:0] rd_addr,
    output logic           reg_write,
    output logic           mem_read,
    output logic           mem_write,
    output logic           mem_to_reg
);

    ex_ctrl_t       ctrl_q;
    logic [RAW-1:0] rs_addr_q;
    logic [RAW-1:0] rt_addr_q;
    logic [DW-1:0]  rs_data_q;
    logic [DW-1:0]  rt_data_q;
    logic [DW-1:0]  imm_q;
    logic [DW-1:0]  fwd_rs_c;
    logic [DW-1:0]  fwd_rt_c;
    logic           hazard_c;
    logic           load_c;

    // A held load whose destination feeds the decoding instruction forces one bubble.
    assign hazard_c = out_valid && ctrl_q.mem_read && (rd_addr != '0) &&
                      ((rs_addr == rd_addr) || (rt_addr == rd_addr));
    assign in_ready = !hazard_c && (!out_valid || out_ready);
    assign load_c   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            ctrl_q    <= '0;
            rd_addr   <= '0;
            rs_addr_q <= '0;
            rt_addr_q <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load_c) begin
            out_valid         <= 1'b1;
            ctrl_q.alu_op     <= alu_op_in;
            ctrl_q.alu_src    <= alu_src_in;
            ctrl_q.reg_write  <= reg_write_in;
            ctrl_q.mem_read   <= mem_read_in;
            ctrl_q.mem_write  <= mem_write_in;
            ctrl_q.mem_to_reg <= mem_to_reg_in;
            rd_addr           <= rd_addr_in;
            rs_addr_q         <= rs_addr;
            rt_addr_q         <= rt_addr;
            rs_data_q         <= rs_data;
            rt_data_q         <= rt_data;
            imm_q             <= imm;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    id_ex_stage_fwd_sel #(.DW(DW), .RAW(RAW)) u_fwd_rs (
        .addr             (rs_addr_q),
        .rf_data          (rs_data_q),
        .ex_mem_reg_write (ex_mem_reg_write),
        .ex_mem_rd        (ex_mem_rd),
        .ex_mem_result    (ex_mem_result),
        .mem_wb_reg_write (mem_wb_reg_write),
        .mem_wb_rd        (mem_wb_rd),
        .mem_wb_result    (mem_wb_result),
        .data_c           (fwd_rs_c)
    );

    id_ex_stage_fwd_sel #(.DW(DW), .RAW(RAW)) u_fwd_rt (
        .addr             (rt_addr_q),
        .rf_data          (rt_data_q),
        .ex_mem_reg_write (ex_mem_reg_write),
        .ex_mem_rd        (ex_mem_rd),
        .ex_mem_result    (ex_mem_result),
        .mem_wb_reg_write (mem_wb_reg_write),
        .mem_wb_rd        (mem_wb_rd),
        .mem_wb_result    (mem_wb_result),
        .data_c           (fwd_rt_c)
    );

    assign input_a    = fwd_rs_c;
    assign store_data = fwd_rt_c;
    assign input_b    = ctrl_q.alu_src ? imm_q : fwd_rt_c;
    assign alu_op     = ctrl_q.alu_op;
    assign reg_write  = ctrl_q.reg_write;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign mem_to_reg = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: accepted instructions are queued and checked while held in EX.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs_addr, rt_addr, rd_addr_in;
    logic [3:0]  alu_op_in;
    logic        alu_src_in, reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in;
    logic        flush;
    logic        ex_mem_reg_write;
    logic [4:0]  ex_mem_rd;
    logic [31:0] ex_mem_result;
    logic        mem_wb_reg_write;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] input_a, input_b, store_data;
    logic [3:0]  alu_op;
    logic [4:0]  rd_addr;
    logic        reg_write, mem_read, mem_write, mem_to_reg;

    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd, imm;
        logic [3:0]  op;
        logic        asrc, rw, mr, mw, m2r;
    } txn_t;

    txn_t exp_q[$];
    bit   mdl_valid;
    int   n_checks;
    int   n_pass;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr_in(rd_addr_in),
        .alu_op_in(alu_op_in), .alu_src_in(alu_src_in), .reg_write_in(reg_write_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
        .flush(flush), .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_rd(ex_mem_rd),
        .ex_mem_result(ex_mem_result), .mem_wb_reg_write(mem_wb_reg_write),
        .mem_wb_rd(mem_wb_rd), .mem_wb_result(mem_wb_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .input_a(input_a), .input_b(input_b), .alu_op(alu_op), .store_data(store_data),
        .rd_addr(rd_addr), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    // Reference bypass: EX/MEM first, then MEM/WB, else register-file data; $0 never forwards.
    function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] rf);
        if (ex_mem_reg_write && ex_mem_rd != 5'd0 && ex_mem_rd == a) return ex_mem_result;
        if (mem_wb_reg_write && mem_wb_rd != 5'd0 && mem_wb_rd == a) return mem_wb_result;
        return rf;
    endfunction

    task automatic drive(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic [31:0] im, input logic [3:0] op, input logic [4:0] ctl);
        in_valid = v;   rs_addr = rs;  rt_addr = rt;  rd_addr_in = rd;
        rs_data = rsd;  rt_data = rtd; imm = im;      alu_op_in = op;
        {alu_src_in, reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in} = ctl;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                           input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
        ex_mem_reg_write = ew; ex_mem_rd = erd; ex_mem_result = eres;
        mem_wb_reg_write = mw; mem_wb_rd = mrd; mem_wb_result = mres;
    endtask

    // Check the current cycle against the model, then advance one clock and update the model.
    task automatic cycle(input string tag);
        txn_t t;
        txn_t n;
        logic haz;
        logic exp_ready;
        logic [31:0] exp_st;
        #1;
        haz = 1'b0;
        if (mdl_valid && exp_q.size() > 0) begin
            t = exp_q[0];
            haz = t.mr && (t.rd != 5'd0) && (rs_addr == t.rd || rt_addr == t.rd);
        end
        exp_ready = !haz && (!mdl_valid || out_ready);
        check_eq({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
        check_eq({tag, ".out_valid"}, 32'(out_valid), 32'(mdl_valid));
        if (mdl_valid && exp_q.size() > 0) begin
            exp_st = ref_fwd(t.rt, t.rtd);
            check_eq({tag, ".alu_op"}, 32'(alu_op), 32'(t.op));
            check_eq({tag, ".rd_addr"}, 32'(rd_addr), 32'(t.rd));
            check_eq({tag, ".ctrl"}, 32'({reg_write, mem_read, mem_write, mem_to_reg}),
                     32'({t.rw, t.mr, t.mw, t.m2r}));
            check_eq({tag, ".input_a"}, input_a, ref_fwd(t.rs, t.rsd));
            check_eq({tag, ".store_data"}, store_data, exp_st);
            check_eq({tag, ".input_b"}, input_b, t.asrc ? t.imm : exp_st);
        end
        n = '{rs: rs_addr, rt: rt_addr, rd: rd_addr_in, rsd: rs_data, rtd: rt_data, imm: imm,
              op: alu_op_in, asrc: alu_src_in, rw: reg_write_in, mr: mem_read_in,
              mw: mem_write_in, m2r: mem_to_reg_in};
        @(posedge clk);
        #1;
        if (flush) begin
            mdl_valid = 1'b0;
            exp_q.delete();
        end else begin
            if (mdl_valid && out_ready) begin
                void'(exp_q.pop_front());
                mdl_valid = 1'b0;
            end
            if (in_valid && exp_ready) begin
                exp_q.push_back(n);
                mdl_valid = 1'b1;
            end
        end
    endtask

    initial begin
        n_checks = 0; n_pass = 0; mdl_valid = 1'b0;
        rst_n = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, ALU_PASSA, 5'b00000);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst.out_valid", 32'(out_valid), 32'h0);
        check_eq("rst.alu_op", 32'(alu_op), 32'h0);
        check_eq("rst.rd_addr", 32'(rd_addr), 32'h0);
        check_eq("rst.in_ready", 32'(in_ready), 32'h1);
        check_eq("rst.input_a", input_a, 32'h0);
        check_eq("rst.input_b", input_b, 32'h0);
        check_eq("rst.store_data", store_data, 32'h0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Plain R-type, then immediate form.
        drive(1'b1, 5'd1, 5'd2, 5'd4, 32'h100, 32'h200, 32'h0, ALU_ADD, 5'b01000);
        cycle("add");
        drive(1'b1, 5'd6, 5'd7, 5'd8, 32'h5, 32'h6, 32'h1234, ALU_OR, 5'b11000);
        cycle("ori_in");
        // Rs=3 captured; both bypass stages will target $3 while it is in EX.
        drive(1'b1, 5'd3, 5'd9, 5'd10, 32'h33, 32'h44, 32'h0, ALU_SUB, 5'b01000);
        cycle("ori_ex");
        drive(1'b1, 5'd0, 5'd0, 5'd11, 32'h0, 32'h0, 32'h0, ALU_AND, 5'b01000);
        set_fwd(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
        cycle("prio");
        // $0 sources with bypass writers aimed at $0.
        drive(1'b1, 5'd12, 5'd13, 5'd14, 32'h1, 32'h2, 32'h0, ALU_XOR, 5'b00001);
        set_fwd(1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE);
        cycle("zero");
        // MEM/WB-only hit on Rs, EX/MEM hit on Rt; then a load to $5.
        drive(1'b1, 5'd1, 5'd2, 5'd5, 32'h1000, 32'h0, 32'h4, ALU_ADD, 5'b11101);
        set_fwd(1'b1, 5'd13, 32'hAB, 1'b1, 5'd12, 32'h77);
        cycle("memwb");
        // Dependent on the load: stalled once, accepted after the bubble.
        drive(1'b1, 5'd5, 5'd6, 5'd7, 32'h50, 32'h60, 32'h0, ALU_SLT, 5'b01000);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        cycle("lw_haz");
        cycle("bubble");
        // Backpressure: held instruction stays put for three cycles.
        drive(1'b1, 5'd2, 5'd3, 5'd9, 32'hA, 32'hB, 32'h0, ALU_NOR, 5'b01000);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle("stall");
        out_ready = 1'b1;
        cycle("release");
        // Flush drops both the held and the incoming instruction.
        drive(1'b1, 5'd4, 5'd4, 5'd15, 32'hC, 32'hD, 32'h0, ALU_ADD, 5'b01000);
        flush = 1'b1;
        cycle("flush");
        flush = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, ALU_PASSA, 5'b00000);
        cycle("post_flush");
        // Asynchronous reset while an instruction is held.
        drive(1'b1, 5'd8, 5'd9, 5'd16, 32'h88, 32'h99, 32'h0, ALU_SUB, 5'b01000);
        cycle("pre_rst");
        drive(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, ALU_PASSA, 5'b00000);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst.out_valid", 32'(out_valid), 32'h0);
        check_eq("arst.alu_op", 32'(alu_op), 32'h0);
        check_eq("arst.in_ready", 32'(in_ready), 32'h1);
        mdl_valid = 1'b0;
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, 5'd17, 5'd18, 5'd19, 32'h170, 32'h180, 32'h0, ALU_ADD, 5'b01000);
        cycle("after_rst");
        drive(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, ALU_PASSA, 5'b00000);
        cycle("drain");
        cycle("idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
